nibble_frame_acc: RTL and testbench



---
 rtl/nibble_pkg.sv | 13 +
 rtl/nibble_sat_add.sv | 24 ++
 rtl/nibble_frame_acc.sv | 163 ++++++++++++++++
 tb/tb_nibble_frame_acc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble frame accumulator.
package nibble_pkg;

    // Width of one nibble-adder sum and the largest sum two nibbles can produce.
    localparam int Q_W   = 5;
    localparam int Q_MAX = 30;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage : nibble_pkg

// File: rtl/nibble_sat_add.sv
// Unsigned saturating add of one nibble-adder sum into an ACC_W accumulator.
// The sample is zero-extended to ACC_W+1 bits, so a carry into bit ACC_W
// means the true sum no longer fits and the result is clamped to all-ones.
module nibble_sat_add
    import nibble_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [Q_W-1:0]   q,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    logic [ACC_W:0] ext_sum;

    // Widened add, then clamp on carry-out.
    always_comb begin
        ext_sum = {1'b0, acc} + {{(ACC_W + 1 - Q_W){1'b0}}, q};
        sat     = ext_sum[ACC_W];
        sum     = ext_sum[ACC_W] ? {ACC_W{1'b1}} : ext_sum[ACC_W-1:0];
    end

endmodule : nibble_sat_add

// File: rtl/nibble_frame_acc.sv
// Frame accumulator: sums COUNT nibble-adder samples with saturation and
// presents one held frame result over a valid/ready handshake.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_ACCUM | accepting samples; in_ready=1, working acc/counter/flags live
//   ST_HOLD  | frame result held on out_*; out_valid=1, no samples taken
//
// in_ready and out_valid are decoded only from the state register, so there
// is no combinational path from in_valid or out_ready to either handshake
// output. The frame result lives in its own registers so it stays stable
// while held, independent of the working accumulator.
module nibble_frame_acc
    import nibble_pkg::*;
#(
    parameter int COUNT = 16,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Q_W-1:0]   in_q,
    input  logic             in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_mix,
    output logic             out_ctrl
);

    localparam int                CNT_W    = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             mix_q, mix_d;
    logic             tag_q, tag_d;

    logic [ACC_W-1:0] res_sum_q, res_sum_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_mix_q, res_mix_d;
    logic             res_ctrl_q, res_ctrl_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_sat;
    logic [CNT_W-1:0] cnt_inc;
    logic             take_in;
    logic             take_out;
    logic             first_smp;
    logic             smp_ovf;
    logic             smp_mix;
    logic             smp_tag;

    nibble_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc (acc_q),
        .q   (in_q),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_HOLD);
    end

    // Per-sample view of the frame flags including the sample being accepted.
    always_comb begin
        cnt_inc   = cnt_q + CNT_W'(1);
        first_smp = (cnt_q == '0);
        smp_tag   = first_smp ? in_ctrl : tag_q;
        smp_mix   = mix_q | (!first_smp && (in_ctrl != tag_q));
        smp_ovf   = ovf_q | add_sat;
        take_in   = (state_q == ST_ACCUM) && in_valid;
        take_out  = (state_q == ST_HOLD) && out_ready;
    end

    // Next-state and datapath update; flush overrides any same-cycle transfer.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        mix_d      = mix_q;
        tag_d      = tag_q;
        res_sum_d  = res_sum_q;
        res_ovf_d  = res_ovf_q;
        res_mix_d  = res_mix_q;
        res_ctrl_d = res_ctrl_q;

        if (flush) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            mix_d   = 1'b0;
            tag_d   = 1'b0;
        end else if (take_in) begin
            acc_d = add_sum;
            cnt_d = cnt_inc;
            ovf_d = smp_ovf;
            mix_d = smp_mix;
            tag_d = smp_tag;
            if (cnt_inc == CNT_LAST) begin
                res_sum_d  = add_sum;
                res_ovf_d  = smp_ovf;
                res_mix_d  = smp_mix;
                res_ctrl_d = smp_tag;
                state_d    = ST_HOLD;
            end
        end else if (take_out) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            mix_d   = 1'b0;
            tag_d   = 1'b0;
        end
    end

    // State, working accumulator and held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            mix_q      <= 1'b0;
            tag_q      <= 1'b0;
            res_sum_q  <= '0;
            res_ovf_q  <= 1'b0;
            res_mix_q  <= 1'b0;
            res_ctrl_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            mix_q      <= mix_d;
            tag_q      <= tag_d;
            res_sum_q  <= res_sum_d;
            res_ovf_q  <= res_ovf_d;
            res_mix_q  <= res_mix_d;
            res_ctrl_q <= res_ctrl_d;
        end
    end

    // Result port mapping.
    always_comb begin
        out_sum  = res_sum_q;
        out_ovf  = res_ovf_q;
        out_mix  = res_mix_q;
        out_ctrl = res_ctrl_q;
    end

endmodule : nibble_frame_acc

// File: tb/tb_nibble_frame_acc.sv
// Directed bench: instance a (COUNT=4) for frame/handshake/flush behaviour,
// instance b (COUNT=16) for mid-frame reset and saturation.
module tb_nibble_frame_acc;

    logic       clk;
    logic       rst_n;

    logic       a_flush, a_in_valid, a_in_ready, a_in_ctrl;
    logic [4:0] a_in_q;
    logic       a_out_valid, a_out_ready, a_out_ovf, a_out_mix, a_out_ctrl;
    logic [7:0] a_out_sum;

    logic       b_flush, b_in_valid, b_in_ready, b_in_ctrl;
    logic [4:0] b_in_q;
    logic       b_out_valid, b_out_ready, b_out_ovf, b_out_mix, b_out_ctrl;
    logic [7:0] b_out_sum;

    int n_checks;
    int n_errors;

    nibble_frame_acc #(.COUNT(4), .ACC_W(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_q      (a_in_q),
        .in_ctrl   (a_in_ctrl),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_sum   (a_out_sum),
        .out_ovf   (a_out_ovf),
        .out_mix   (a_out_mix),
        .out_ctrl  (a_out_ctrl)
    );

    nibble_frame_acc #(.COUNT(16), .ACC_W(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_q      (b_in_q),
        .in_ctrl   (b_in_ctrl),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_ovf   (b_out_ovf),
        .out_mix   (b_out_mix),
        .out_ctrl  (b_out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_a(input logic [4:0] q, input logic c);
        a_in_valid = 1'b1;
        a_in_q     = q;
        a_in_ctrl  = c;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [4:0] q, input logic c);
        b_in_valid = 1'b1;
        b_in_q     = q;
        b_in_ctrl  = c;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic consume_a(input string tag);
        chk({tag, "_valid_before"}, a_out_valid, 1);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        chk({tag, "_valid_after"}, a_out_valid, 0);
        chk({tag, "_ready_after"}, a_in_ready, 1);
    endtask

    task automatic consume_b(input string tag);
        chk({tag, "_valid_before"}, b_out_valid, 1);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        chk({tag, "_valid_after"}, b_out_valid, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        a_flush = 0; a_in_valid = 0; a_in_q = 0; a_in_ctrl = 0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_q = 0; b_in_ctrl = 0; b_out_ready = 0;

        #12;
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_sum", a_out_sum, 0);
        chk("rst_out_flags", {a_out_ovf, a_out_mix, a_out_ctrl}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic frame 3+7+10+2 = 22
        send_a(3, 0); send_a(7, 0); send_a(10, 0);
        chk("basic_not_yet", a_out_valid, 0);
        send_a(2, 0);
        chk("basic_sum", a_out_sum, 22);
        chk("basic_flags", {a_out_ovf, a_out_mix, a_out_ctrl}, 3'b000);
        chk("basic_in_ready", a_in_ready, 0);
        consume_a("basic");

        // Mixed tags 1,1,0,1 with q=1 each -> sum 4, mix=1, ctrl=1
        send_a(1, 1); send_a(1, 1); send_a(1, 0); send_a(1, 1);
        chk("mix_sum", a_out_sum, 4);
        chk("mix_flags", {a_out_ovf, a_out_mix, a_out_ctrl}, 3'b011);
        consume_a("mix");

        // Backpressure: 4x5 = 20 held for 10 cycles with in_valid asserted
        send_a(5, 0); send_a(5, 0); send_a(5, 0); send_a(5, 0);
        a_in_valid = 1'b1;
        a_in_q     = 9;
        a_in_ctrl  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", a_in_ready, 0);
            chk("bp_valid", a_out_valid, 1);
            chk("bp_sum", a_out_sum, 20);
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        chk("bp_release_valid", a_out_valid, 0);
        chk("bp_release_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        send_a(1, 0); send_a(1, 0); send_a(1, 0);
        chk("bp_next_sum", a_out_sum, 12);
        consume_a("bp_next");

        // Flush on the third transfer: that sample and the first two are lost
        send_a(4, 0); send_a(4, 0);
        a_flush = 1'b1;
        send_a(4, 0);
        a_flush = 1'b0;
        send_a(2, 0); send_a(2, 0); send_a(2, 0);
        chk("flush_not_yet", a_out_valid, 0);
        send_a(2, 0);
        chk("flush_sum", a_out_sum, 8);
        consume_a("flush");

        // Flush while holding a result: out_valid drops, next frame starts clean
        send_a(1, 0); send_a(2, 0); send_a(3, 0); send_a(4, 0);
        chk("hold_sum", a_out_sum, 10);
        a_flush = 1'b1;
        @(posedge clk);
        #1;
        a_flush = 1'b0;
        chk("hold_flush_valid", a_out_valid, 0);
        chk("hold_flush_ready", a_in_ready, 1);
        send_a(6, 0); send_a(6, 0); send_a(6, 0); send_a(6, 0);
        chk("after_flush_sum", a_out_sum, 24);
        chk("after_flush_ovf", a_out_ovf, 0);

        // Asynchronous reset while holding: outputs clear without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", a_out_valid, 0);
        chk("async_rst_sum", a_out_sum, 0);
        chk("async_rst_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset after 5 samples on instance b; next frame must sum from zero
        for (int i = 0; i < 5; i++) send_b(30, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("b_rst_ready", b_in_ready, 1);
        chk("b_rst_valid", b_out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) send_b(1, 0);
        chk("b_clean_not_yet", b_out_valid, 0);
        send_b(1, 0);
        chk("b_clean_sum", b_out_sum, 16);
        chk("b_clean_ovf", b_out_ovf, 0);
        consume_b("b_clean");

        // Exactly 2^8-1 without overflow: 15x17 + 0 = 255
        for (int i = 0; i < 15; i++) send_b(17, 0);
        send_b(0, 0);
        chk("b_edge_sum", b_out_sum, 255);
        chk("b_edge_ovf", b_out_ovf, 0);
        consume_b("b_edge");

        // Saturation: 16x30 = 480 clamps to 255
        for (int i = 0; i < 16; i++) send_b(30, 1);
        chk("b_sat_sum", b_out_sum, 255);
        chk("b_sat_flags", {b_out_ovf, b_out_mix, b_out_ctrl}, 3'b101);
        consume_b("b_sat");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_nibble_frame_acc
